// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param. The master drives requests
// and write data; the slave (the FIFO) returns data, status flags and error pulses.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              wr_overflow;
    logic              rd_underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, empty, full, almost_empty, almost_full,
               count, wr_overflow, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, empty, full, almost_empty, almost_full,
               count, wr_overflow, rd_underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/empty thresholds,
// guarded access (rejected requests pulse an error flag) and optional FWFT read.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_empty;
    logic              r_almost_full;
    logic              r_wr_overflow;
    logic              r_rd_underflow;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [CW-1:0]     w_count_next;

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_rd_acc = bus.rd_en & ~r_empty;
    assign w_wr_acc = bus.wr_en & (~r_full | w_rd_acc);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count        <= w_count_next;
            // Flags follow the next count so they always agree with count.
            r_empty        <= (w_count_next == '0);
            r_full         <= (w_count_next == CW'(DEPTH));
            r_almost_empty <= (w_count_next <= CW'(AE_LEVEL));
            r_almost_full  <= (w_count_next >= CW'(AF_LEVEL));
            r_wr_overflow  <= bus.wr_en & ~w_wr_acc;
            r_rd_underflow <= bus.rd_en & ~w_rd_acc;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head is always visible; valid whenever something is stored.
            assign bus.rd_data  = r_mem[r_rd_ptr];
            assign bus.rd_valid = ~r_empty;
        end else begin : g_reg_read
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign bus.rd_data  = r_rd_data;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

    assign bus.count        = r_count;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.wr_overflow  = r_wr_overflow;
    assign bus.rd_underflow = r_rd_underflow;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with configurable data width and depth, fill-level output, programmable almost-full/almost-empty thresholds, and guarded access. Writes when full and reads when empty are rejected and reported, never corrupting state. Optional first-word-fall-through (FWFT) read mode. Sits between producer and consumer blocks in the same clock domain and replaces the fixed 8-bit x 16 FIFO in new designs.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- Widths: AW = $clog2(DEPTH); CW = AW+1

- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request (FWFT=1: pop of the current head)
- rd_data  out  DATA_W  read data
- rd_valid  out  1  FWFT=0: pulses with rd_data one cycle after an accepted read; FWFT=1: equals !empty
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- count  out  CW  current number of stored entries, 0..DEPTH
- wr_overflow  out  1  one-cycle pulse: a write was rejected
- rd_underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage: DEPTH x DATA_W array, not reset. wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- Write accept: wr_acc = wr_en & (!full | rd_acc). A full FIFO accepts a write only if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & !empty. A read in the same cycle as a write to an empty FIFO is rejected; the write is accepted.
- On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr++.
- On rd_acc: rd_ptr++.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted.
- Rejected access: wr_en & !wr_acc pulses wr_overflow; rd_en & !rd_acc pulses rd_underflow. Pointers, count and memory are unchanged.
- FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1: rd_data = mem[rd_ptr] combinationally; rd_data is meaningful only while !empty.
- All flags are registered, derived from next-state count, so each flag is consistent with count in the same cycle.
- Reset (rst_n=0 at an edge) aborts any in-flight operation; accesses in that cycle are ignored.
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_valid 0, rd_data 0, wr_overflow 0, rd_underflow 0.

## Timing
- Write latency: a write accepted at edge N updates count and flags after edge N.
- FWFT=1: data written at edge N appears on rd_data, with empty=0, in cycle N+1.
- FWFT=0: a read accepted at edge N presents rd_data with rd_valid=1 in cycle N+1, for one cycle.
- Sustained throughput: one write and one read per cycle, at any fill level 1..DEPTH.
- wr_overflow and rd_underflow pulse in the cycle after the rejected request.
- No combinational path from wr_en or rd_en to any output. The FWFT rd_data path depends only on registers.

## Test plan
- Reset, fill and drain: DATA_W=8, DEPTH=16. Hold rst_n=0 for 2 cycles, then write 0x00..0x0F on 16 cycles -> count=16, full=1, almost_full=1 from count=14. Read 16 -> data 0x00..0x0F in order; rd_valid pulses 16 times; empty=1.
- Overflow and underflow: with the FIFO full, assert wr_en=1 with 0xAA -> wr_overflow pulses, count stays 16, 0xAA is never read. With the FIFO empty, assert rd_en -> rd_underflow pulses, rd_valid=0, count stays 0.
- Simultaneous access at both bounds:
  - Full + wr/rd with 0x55 -> count stays 16, head read out, 0x55 becomes the tail.
  - Empty + wr/rd with 0x33 -> write accepted, rd_underflow pulses, count=1.
- Pointer wrap: 40 cycles of simultaneous wr/rd at count=3 with an incrementing pattern -> output sequence is unbroken across two pointer wraps.
- FWFT=1: write 0x5A -> rd_data=0x5A and rd_valid=1 the next cycle without rd_en. rd_en pops it -> empty=1 the next cycle.
- Reset mid-operation: at count=9, apply rst_n=0 for 1 cycle while wr_en=rd_en=1 -> all outputs return to their reset values and count=0. The next write/read returns the new data, not stale data.
